// File: rtl/channel_model_if.sv
// channel_model_if: control, sample and status bundle for channel_model.
// master drives enable/mode/ber_thresh/channel_input and observes the rest;
// slave (the channel) drives channel_output, out_valid, sample_tick and err_count.
interface channel_model_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic [1:0]       mode;
  logic [7:0]       ber_thresh;
  logic [WIDTH-1:0] channel_input;
  logic [WIDTH-1:0] channel_output;
  logic             out_valid;
  logic             sample_tick;
  logic [15:0]      err_count;
  modport master (
    output enable, mode, ber_thresh, channel_input,
    input  channel_output, out_valid, sample_tick, err_count
  );
  modport slave (
    input  enable, mode, ber_thresh, channel_input,
    output channel_output, out_valid, sample_tick, err_count
  );
endinterface

// File: rtl/channel_model.sv
// channel_model: sample-rate channel impairment model (delay + pass/noise/bit-flip/burst erasure).
// Ports: CLOCK_50 system clock, reset_n async active-low reset,
//   ch (slave): enable, mode, ber_thresh, channel_input in;
//               channel_output, out_valid, sample_tick, err_count out.
module channel_model #(
  parameter int          WIDTH       = 16,
  parameter int          DIV         = 5000,
  parameter int          DELAY       = 4,
  parameter int          NOISE_SHIFT = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic            CLOCK_50,
  input logic            reset_n,
  channel_model_if.slave ch
);
  localparam int CW = $clog2(DIV);
  localparam int FW = $clog2(DELAY + 1);
  localparam int LW = $clog2(WIDTH);
  localparam logic [15:0] SEED_NZ = (SEED == 16'd0) ? 16'd1 : SEED;
  typedef enum logic {IDLE, BURST} state_t;
  state_t             state, state_n;
  logic [2:0]         rem, rem_n;
  logic [CW-1:0]      cnt;
  logic               tick, sample_tick, valid, hit;
  logic [15:0]        lfsr, errs;
  logic [WIDTH-1:0]   line [DELAY];
  logic [FW-1:0]      fill;
  logic [WIDTH-1:0]   d, f, out, noise, sat, flip;
  logic signed [31:0] wide;
  logic [WIDTH:0]     sum;
  // tick is the edge at which the sample period completes; sample_tick is its registered echo
  assign tick  = ch.enable && cnt == CW'(DIV - 1);
  assign d     = line[DELAY-1];
  assign hit   = lfsr[7:0] < ch.ber_thresh;
  assign wide  = 32'($signed(lfsr));
  assign noise = WIDTH'(wide >>> NOISE_SHIFT);
  assign sum   = {d[WIDTH-1], d} + {noise[WIDTH-1], noise};
  // overflow when the two top bits of the widened sum disagree; clamp toward the sign of the sum
  assign sat   = (sum[WIDTH] != sum[WIDTH-1]) ?
                 (sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                 sum[WIDTH-1:0];
  assign flip  = d ^ (WIDTH'(1) << lfsr[8 +: LW]);
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rem   <= '0;
    end else if (tick) begin
      state <= state_n;
      rem   <= rem_n;
    end
  // rem holds the erased samples still owed after the current one, so a burst is r[10:8]+1 samples long
  always_comb begin
    state_n = state;
    rem_n   = rem;
    if (ch.mode != 2'b11)
      state_n = IDLE;
    else if (state == BURST) begin
      rem_n   = rem - 3'd1;
      state_n = (rem == 3'd1) ? IDLE : BURST;
    end else if (hit && lfsr[10:8] != 3'd0) begin
      state_n = BURST;
      rem_n   = lfsr[10:8];
    end
  end
  always_comb begin
    f = d;
    f = ch.mode == 2'b01 ? sat :
        ch.mode == 2'b10 ? (hit ? flip : d) :
        ch.mode == 2'b11 ? ((state == BURST || hit) ? '0 : d) : d;
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      valid       <= 1'b0;
      lfsr        <= SEED_NZ;
      fill        <= '0;
      out         <= '0;
      errs        <= '0;
      for (int i = 0; i < DELAY; i++) line[i] <= '0;
    end else begin
      sample_tick <= tick;
      valid       <= tick && fill == FW'(DELAY);
      if (ch.enable) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        line[0] <= ch.channel_input;
        for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
        if (fill != FW'(DELAY)) fill <= fill + 1'b1;
        out <= f;
        if (fill == FW'(DELAY) && f != d && errs != 16'hFFFF) errs <= errs + 16'd1;
      end
    end
  assign ch.channel_output = out;
  assign ch.out_valid      = valid;
  assign ch.sample_tick    = sample_tick;
  assign ch.err_count      = errs;
endmodule

// File: tb/tb_channel_model.sv
// tb_channel_model: table-driven and randomized checks of channel_model against a reference model.
module tb_channel_model;
  localparam int W = 16, DIV = 4, DELAY = 2, NS = 0;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  channel_model_if #(.WIDTH(W)) ch();
  channel_model #(.WIDTH(W), .DIV(DIV), .DELAY(DELAY), .NOISE_SHIFT(NS), .SEED(SEED)) dut (
    .CLOCK_50(clk),
    .reset_n(rst_n),
    .ch(ch)
  );
  typedef struct {
    logic [15:0] din;
    logic [15:0] out;
    logic        valid;
  } vec_t;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] m_line [DELAY];
  int          m_fill, m_left;
  logic [15:0] m_lfsr, m_err, m_out, m_d;
  logic        m_valid;
  logic [15:0] cur_in;
  logic [1:0]  cur_mode;
  logic [7:0]  cur_thr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
  endfunction
  task automatic model_reset;
    for (int i = 0; i < DELAY; i++) m_line[i] = '0;
    m_fill = 0; m_left = 0; m_lfsr = SEED; m_err = '0; m_out = '0; m_d = '0; m_valid = 1'b0;
  endtask
  task automatic model_tick;
    logic [15:0] r, d;
    logic hit;
    int s;
    r = m_lfsr;
    d = m_line[DELAY-1];
    hit = r[7:0] < cur_thr;
    case (cur_mode)
      2'd0: m_out = d;
      2'd1: begin
        s = int'($signed(d)) + (int'($signed(r)) >>> NS);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        m_out = 16'(s);
      end
      2'd2: m_out = hit ? d ^ (16'h1 << r[11:8]) : d;
      default:
        if (m_left > 0) begin m_out = '0; m_left--; end
        else if (hit) begin m_out = '0; m_left = int'(r[10:8]); end
        else m_out = d;
    endcase
    if (cur_mode != 2'd3) m_left = 0;
    m_valid = (m_fill == DELAY);
    if (m_valid && m_out != d && m_err != 16'hFFFF) m_err++;
    m_d = d;
    for (int i = DELAY - 1; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0] = cur_in;
    if (m_fill < DELAY) m_fill++;
    m_lfsr = lfsr_next(r);
  endtask
  task automatic apply(input logic [15:0] din, input logic [1:0] m, input logic [7:0] th);
    cur_in = din; cur_mode = m; cur_thr = th;
    ch.channel_input = din; ch.mode = m; ch.ber_thresh = th;
  endtask
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!ch.sample_tick) chk("valid_off_tick", 32'(ch.out_valid), 32'd0);
    end while (!ch.sample_tick && cyc < 8 * DIV);
    if (!ch.sample_tick) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", cyc);
    end
  endtask
  task automatic check_tick;
    model_tick;
    chk("out", 32'(ch.channel_output), 32'(m_out));
    chk("out_valid", 32'(ch.out_valid), 32'(m_valid));
    chk("err_count", 32'(ch.err_count), 32'(m_err));
  endtask
  task automatic step(input logic [15:0] din, input logic [1:0] m, input logic [7:0] th);
    int c;
    apply(din, m, th);
    wait_tick(c);
    check_tick;
  endtask
  initial begin
    vec_t tbl [5];
    int c, hits_pos, hits_neg, zeros, guard;
    logic [15:0] r, held;
    tbl[0] = '{16'd1, 16'd0, 1'b0};
    tbl[1] = '{16'd2, 16'd0, 1'b0};
    tbl[2] = '{16'd3, 16'd1, 1'b1};
    tbl[3] = '{16'd4, 16'd2, 1'b1};
    tbl[4] = '{16'd5, 16'd3, 1'b1};
    ch.enable = 1'b1;
    apply(16'd0, 2'd0, 8'd0);
    model_reset;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(ch.channel_output), 32'd0);
    chk("rst_valid", 32'(ch.out_valid), 32'd0);
    chk("rst_tick", 32'(ch.sample_tick), 32'd0);
    chk("rst_err", 32'(ch.err_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i].din, 2'd0, 8'd0);
      wait_tick(c);
      if (i == 0) chk("first_tick_cycles", 32'(c), 32'(DIV));
      check_tick;
      chk("tbl_out", 32'(ch.channel_output), 32'(tbl[i].out));
      chk("tbl_valid", 32'(ch.out_valid), 32'(tbl[i].valid));
      chk("tbl_err", 32'(ch.err_count), 32'd0);
    end
    hits_pos = 0; hits_neg = 0;
    for (int i = 0; i < 12; i++) begin
      r = m_lfsr;
      step(16'h7FFF, 2'd1, 8'd0);
      if (m_d == 16'h7FFF && !r[15]) begin hits_pos++; chk("sat_pos", 32'(ch.channel_output), 32'h7FFF); end
    end
    for (int i = 0; i < 12; i++) begin
      r = m_lfsr;
      step(16'h8000, 2'd1, 8'd0);
      if (m_d == 16'h8000 && r[15]) begin hits_neg++; chk("sat_neg", 32'(ch.channel_output), 32'h8000); end
    end
    chk("sat_pos_seen", 32'(hits_pos > 0), 32'd1);
    chk("sat_neg_seen", 32'(hits_neg > 0), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(ch.channel_output), 32'd0);
    chk("midrst_valid", 32'(ch.out_valid), 32'd0);
    chk("midrst_tick", 32'(ch.sample_tick), 32'd0);
    chk("midrst_err", 32'(ch.err_count), 32'd0);
    model_reset;
    apply(16'h0101, 2'd2, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(c);
    chk("midrst_first_tick", 32'(c), 32'(DIV));
    check_tick;
    for (int i = 0; i < 100; i++) begin
      step(16'($urandom), 2'd2, 8'd0);
      chk("flip_thr0_pass", 32'(ch.channel_output), 32'(m_d));
    end
    chk("flip_thr0_err", 32'(ch.err_count), 32'd0);
    for (int i = 0; i < 60; i++) begin
      r = m_lfsr;
      step(16'($urandom), 2'd2, 8'hFF);
      chk("flip_one_bit", 32'($countones(ch.channel_output ^ m_d)), (r[7:0] != 8'hFF) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      guard = 0;
      while (!(m_lfsr[10:8] == 3'd3 && m_lfsr[7:0] != 8'hFF) && guard < 300) begin
        step(16'($urandom) | 16'h1, 2'd0, 8'd0);
        guard++;
      end
      chk("burst_seed_found", 32'(guard < 300), 32'd1);
      step(16'($urandom) | 16'h1, 2'd3, 8'hFF);
      chk("burst_start_zero", 32'(ch.channel_output), 32'd0);
      if (k == 0) begin
        zeros = 1;
        for (int i = 0; i < 4; i++) begin
          step(16'($urandom) | 16'h1, 2'd3, 8'd0);
          if (ch.channel_output == 16'd0) zeros++;
        end
        chk("burst_len", 32'(zeros), 32'd4);
        chk("burst_end_pass", 32'(ch.channel_output), 32'(m_d));
      end else begin
        step(16'($urandom) | 16'h1, 2'd3, 8'd0);
        chk("burst_mid_zero", 32'(ch.channel_output), 32'd0);
        step(16'($urandom) | 16'h1, 2'd0, 8'd0);
        chk("burst_exit_nonzero", 32'(ch.channel_output != 16'd0), 32'd1);
        chk("burst_exit_pass", 32'(ch.channel_output), 32'(m_d));
      end
    end
    step(16'h1357, 2'd2, 8'h80);
    apply(16'h2468, 2'd2, 8'h80);
    @(negedge clk);
    ch.enable = 1'b0;
    held = m_out;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      chk("hold_no_tick", 32'(ch.sample_tick), 32'd0);
      chk("hold_out", 32'(ch.channel_output), 32'(held));
    end
    ch.enable = 1'b1;
    wait_tick(c);
    chk("resume_spacing", 32'(c), 32'(DIV - 1));
    check_tick;
    for (int i = 0; i < 400; i++)
      step(16'($urandom), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/channel_model.md
# channel_model

Parametrised successor to the 16-bit `channel` block: a single-clock, sample-rate channel impairment model for the digital communication chain. It sits between the transmitter modulator output and the receiver front end. It holds each sample for a programmable number of sample periods, then applies a run-time selected impairment: pass-through, saturating additive pseudo-noise, single-bit flips, or burst erasure. The sample rate comes from an internal divider on `CLOCK_50` rather than a second clock. It also reports out-valid strobes and a running error count for BER measurement.

## Interface
- `WIDTH`, 16: sample width, signed two's complement; power of two in 8..32.
- `DIV`, 5000: `CLOCK_50` cycles per sample period (5000 gives 10 kHz); ≥ 2.
- `DELAY`, 4: channel latency in sample periods; ≥ 1.
- `NOISE_SHIFT`, 8: arithmetic right shift applied to the 16-bit LFSR word to form noise.
- `SEED`, 16'hACE1: LFSR reset value; a SEED of 0 is replaced by 1.
- `CLOCK_50`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run; 0 freezes the divider, so no ticks are issued.
- `mode`  in  2  00 pass, 01 additive noise, 10 bit flip, 11 burst erasure.
- `ber_thresh`  in  8  event probability is ber_thresh/256; 0 means never.
- `channel_input`  in  WIDTH  transmitted sample.
- `channel_output`  out  WIDTH  impaired sample; reset 0.
- `out_valid`  out  1  one-cycle strobe when `channel_output` updates; reset 0.
- `sample_tick`  out  1  registered one-cycle sample strobe; reset 0.
- `err_count`  out  16  count of samples where output ≠ delayed input; saturates at 16'hFFFF; reset 0.

## Operation
- **Divider.** The count runs 0..DIV-1 while `enable` is 1 and holds while `enable` is 0. `sample_tick` is registered high for the cycle after count == DIV-1; the count wraps to 0.
- **LFSR.** 16-bit Galois, mask 16'hB400, shifts right. It advances once per tick, after use. It is never zero.
- **On each tick edge:**
  - The delay line shifts and `channel_input` enters stage 0.
  - `channel_output` ← f(stage DELAY-1 old value `d`, current LFSR `r`).
  - The fill counter increments, saturating at DELAY.
- **f, mode 00:** `d`.
- **f, mode 01:** `d` + sign-extended/truncated (`r` as signed >>> NOISE_SHIFT).
  - Signed saturating add: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- **f, mode 10:** if `r[7:0]` < `ber_thresh`, flip bit `r[15:8]` mod WIDTH (low log2(WIDTH) bits); else `d`.
- **f, mode 11: burst FSM.**
  - In IDLE: if `r[7:0]` < `ber_thresh`, go to BURST with remaining = `r[10:8]` + 1 and output 0 this sample; else output `d`.
  - In BURST: output 0 and decrement remaining; return to IDLE when remaining reaches 0.
  - Leaving mode 11 forces IDLE at the next tick.
- **Mode and threshold changes.** `mode` and `ber_thresh` are sampled only at tick edges.
- **out_valid.** High the cycle after a tick edge at which the fill counter was already DELAY. Output from unfilled stages (reset zeros) is driven but not flagged valid.
- **err_count.** Increments at each valid output where `channel_output` ≠ `d`. It is not incremented during fill.
- **Reset.** Asynchronous and immediate, mid-sample included:
  - Divider, delay line, fill counter, FSM, counters and outputs go to 0.
  - LFSR goes to SEED.

## Timing
- Tick period is exactly DIV cycles. With `enable` held high from reset release, the first `sample_tick` occurs at cycle DIV.
- The sample captured at tick k appears on `channel_output` at the tick k+DELAY edge. `out_valid` is coincident with the new value for one cycle.
- Dropping `enable` mid-period pauses the count. Raising it again resumes from the held count; no tick is lost or duplicated.

## Test plan
- **Reset values.** Assert `reset_n` low mid-period → all outputs 0 immediately. After release, the first tick occurs DIV cycles later.
- **Pass-through latency.** DIV=4, DELAY=2, mode 00, inputs 1, 2, 3 on successive ticks → outputs 1, 2, 3 starting at the tick-2 edge. `out_valid` first asserted there; `err_count` = 0.
- **Noise saturation.** Mode 01, NOISE_SHIFT=0, input 16'h7FFF, LFSR word positive → output 16'h7FFF. With a negative word and input 16'h8000 → output 16'h8000.
- **Bit flip.** Mode 10, `ber_thresh` = 0 for 100 samples → output equals delayed input and `err_count` = 0. Then `ber_thresh` = 8'hFF → each flagged sample differs in exactly one bit, and `err_count` matches a reference LFSR model.
- **Burst erasure.** Mode 11 with a seed giving `r[7:0]` < thresh and `r[10:8]` = 3 → exactly 4 consecutive zero outputs, then IDLE. Switching to mode 00 mid-burst → non-zero `d` passes at the next tick.
- **Enable hold.** With `enable` = 0 for 3×DIV cycles → no `sample_tick`, and LFSR and outputs unchanged. On resume, the tick spacing matches the remaining count.
